// File: rtl/pipe_reg_id_ex_elastic.sv
// pipe_reg_id_ex_elastic: elastic ID->EX pipeline register with a 1-entry skid buffer
//   clock/reset(async, active-low), flush drops held entries and this cycle's input
//   in_valid/in_ready/in_instr/in_rd1/in_rd2      : decode-side handshake and payload
//   out_valid/out_ready/out_instr/out_rd1/out_rd2 : execute-side handshake and payload
//   out_dest/out_dest_valid                       : destination field for hazard/forwarding
//   cnt_clr/bubble_cnt                            : saturating count of EX-starved cycles
module pipe_reg_id_ex_elastic #(
    parameter int DATA_W   = 20,
    parameter int DEST_MSB = 15,
    parameter int DEST_LSB = 12,
    parameter int CNT_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_instr,
    input  logic [DATA_W-1:0]            in_rd1,
    input  logic [DATA_W-1:0]            in_rd2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_instr,
    output logic [DATA_W-1:0]            out_rd1,
    output logic [DATA_W-1:0]            out_rd2,
    output logic [DEST_MSB-DEST_LSB:0]   out_dest,
    output logic                         out_dest_valid,
    input  logic                         cnt_clr,
    output logic [CNT_W-1:0]             bubble_cnt
);
    localparam logic [1:0] EMPTY = 2'd0, MAIN = 2'd1, FULL = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] instr_q, instr_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d, skid_rd1_q, skid_rd1_d, skid_rd2_q, skid_rd2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, consume;

    assign out_valid      = state_q != EMPTY;
    assign in_ready       = in_ready_q;
    assign out_instr      = instr_q;
    assign out_rd1        = rd1_q;
    assign out_rd2        = rd2_q;
    assign out_dest       = instr_q[DEST_MSB:DEST_LSB];
    assign out_dest_valid = out_valid & (|out_dest);
    assign bubble_cnt     = cnt_q;

    always_comb begin
        accept       = in_valid & in_ready_q;
        consume      = out_valid & out_ready;
        state_d      = state_q;
        instr_d      = instr_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        skid_instr_d = skid_instr_q;
        skid_rd1_d   = skid_rd1_q;
        skid_rd2_d   = skid_rd2_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (state_q == EMPTY) begin
            if (accept) begin
                {instr_d, rd1_d, rd2_d} = {in_instr, in_rd1, in_rd2};
                state_d = MAIN;
            end
        end else if (state_q == MAIN) begin
            if (accept && consume) begin
                {instr_d, rd1_d, rd2_d} = {in_instr, in_rd1, in_rd2};
            end else if (accept) begin
                // EX stalled: park the new word behind the one on out_*
                {skid_instr_d, skid_rd1_d, skid_rd2_d} = {in_instr, in_rd1, in_rd2};
                state_d = FULL;
            end else if (consume) begin
                state_d = EMPTY;
            end
        end else if (consume) begin
            {instr_d, rd1_d, rd2_d} = {skid_instr_q, skid_rd1_q, skid_rd2_q};
            state_d = MAIN;
        end
        // registered ready: derived from the next state so it never depends on out_ready combinationally
        in_ready_d = state_d != FULL;
        cnt_d = cnt_clr ? '0 : (out_ready && !out_valid && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            instr_q      <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            skid_instr_q <= '0;
            skid_rd1_q   <= '0;
            skid_rd2_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            instr_q      <= instr_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            skid_instr_q <= skid_instr_d;
            skid_rd1_q   <= skid_rd1_d;
            skid_rd2_q   <= skid_rd2_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_id_ex_elastic.sv
// tb_pipe_reg_id_ex_elastic: directed and streaming checks of the elastic ID->EX register
module tb_pipe_reg_id_ex_elastic;
    logic        clock = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
    logic [19:0] in_instr = 0, in_rd1 = 0, in_rd2 = 0;
    logic        in_ready, out_valid, out_dest_valid;
    logic [19:0] out_instr, out_rd1, out_rd2;
    logic [3:0]  out_dest;
    logic [15:0] bubble_cnt;
    logic        in_ready4, out_valid4, out_dest_valid4;
    logic [19:0] out_instr4, out_rd14, out_rd24;
    logic [3:0]  out_dest4;
    logic [3:0]  bubble_cnt4;
    int          tests = 0, fails = 0;

    always #5 clock = ~clock;

    pipe_reg_id_ex_elastic dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rd1(in_rd1), .in_rd2(in_rd2), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_dest(out_dest), .out_dest_valid(out_dest_valid), .cnt_clr(cnt_clr),
        .bubble_cnt(bubble_cnt)
    );

    pipe_reg_id_ex_elastic #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_instr(in_instr), .in_rd1(in_rd1), .in_rd2(in_rd2), .out_valid(out_valid4),
        .out_ready(out_ready), .out_instr(out_instr4), .out_rd1(out_rd14), .out_rd2(out_rd24),
        .out_dest(out_dest4), .out_dest_valid(out_dest_valid4), .cnt_clr(cnt_clr),
        .bubble_cnt(bubble_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [19:0] i, input logic [19:0] a, input logic [19:0] b);
        in_valid = 1;
        in_instr = i;
        in_rd1   = a;
        in_rd2   = b;
    endtask

    initial begin
        logic [19:0] q[$];
        int sent, cyc, cons;
        #2 reset = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_bubble", bubble_cnt, 0);
        step();
        step();
        reset = 1;
        step();

        // 1: single word, latency 1
        send(20'h0A123, 20'd5, 20'd7);
        out_ready = 1;
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_instr", out_instr, 20'h0A123);
        chk("t1_rd1", out_rd1, 5);
        chk("t1_rd2", out_rd2, 7);
        chk("t1_dest", out_dest, 4'hA);
        chk("t1_dest_valid", out_dest_valid, 1);
        chk("t1_bubble", bubble_cnt, 1);
        in_valid = 0;
        step();
        chk("t1_drain", out_valid, 0);

        // 2: fill skid with EX stalled, then drain in order
        out_ready = 0;
        send(20'h11111, 20'h1, 20'h2);
        step();
        chk("t2_ready_main", in_ready, 1);
        send(20'h22222, 20'h3, 20'h4);
        step();
        chk("t2_ready_full", in_ready, 0);
        chk("t2_first", out_instr, 20'h11111);
        in_valid = 0;
        step();
        chk("t2_stable", {out_valid, out_instr, out_rd1}, {1'b1, 20'h11111, 20'h1});
        out_ready = 1;
        step();
        chk("t2_second", {out_valid, out_instr, out_rd1, out_rd2}, {1'b1, 20'h22222, 20'h3, 20'h4});
        chk("t2_ready_back", in_ready, 1);
        step();
        chk("t2_empty", out_valid, 0);

        // 3: flush in FULL and in MAIN; flushed input never appears
        out_ready = 0;
        send(20'h44444, 0, 0);
        step();
        send(20'h55555, 0, 0);
        step();
        chk("t3_full", in_ready, 0);
        flush = 1;
        send(20'h33333, 0, 0);
        step();
        chk("t3_flush_valid", out_valid, 0);
        chk("t3_flush_ready", in_ready, 1);
        chk("t3_flush_data", out_instr, 20'h44444);
        flush = 0;
        send(20'h66666, 0, 0);
        step();
        chk("t3_main", out_instr, 20'h66666);
        flush = 1;
        send(20'h77777, 0, 0);
        step();
        chk("t3_flush_main_valid", out_valid, 0);
        chk("t3_flush_main_data", out_instr, 20'h66666);
        flush = 0;
        in_valid = 0;
        step();
        chk("t3_after_flush", out_valid, 0);

        // 4: random valid/ready stream against a FIFO scoreboard
        sent = 0;
        cyc = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            cyc++;
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_instr = 20'($urandom);
            in_rd1   = in_instr ^ 20'h5A5A5;
            in_rd2   = ~in_instr;
            out_ready = $urandom_range(0, 3) != 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("t4_underflow", out_instr, 20'hxxxxx);
                else begin
                    chk("t4_stream", {out_instr, out_rd1, out_rd2}, {q[0], q[0] ^ 20'h5A5A5, ~q[0]});
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_instr);
                sent++;
            end
            step();
        end
        chk("t4_done", {sent, 32'(q.size())}, {32'd1000, 32'd0});
        in_valid = 0;
        out_ready = 1;
        step();
        cons = 0;
        in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) cons++;
            step();
        end
        chk("t4_throughput", cons, 19);
        in_valid = 0;
        step();

        // 5: bubble counter, saturation on the 4-bit instance, clear
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        chk("t5_clr0", bubble_cnt, 0);
        repeat (10) step();
        chk("t5_ten", bubble_cnt, 10);
        chk("t5_ten4", bubble_cnt4, 10);
        repeat (10) step();
        chk("t5_twenty", bubble_cnt, 20);
        chk("t5_sat4", bubble_cnt4, 15);
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        chk("t5_clr", bubble_cnt, 0);
        chk("t5_clr4", bubble_cnt4, 0);

        // 6: dest-0 entry, then async reset while FULL
        out_ready = 0;
        send(20'h00ABC, 20'h9, 20'h8);
        step();
        chk("t6_dest0", {out_valid, out_dest_valid}, 2'b10);
        send(20'h0F000, 0, 0);
        step();
        chk("t6_full", in_ready, 0);
        #2 reset = 0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_data", {out_instr, out_rd1, out_rd2}, 0);
        chk("t6_rst_bubble", bubble_cnt, 0);
        in_valid = 0;
        step();
        reset = 1;
        step();
        chk("t6_post", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
